// File: rtl/switch_pkg.sv
// Shared definitions for the switch conditioning path: FSM encoding and the
// default qualification length.
package switch_pkg;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'b00,
        WAIT_HIGH = 2'b01,
        IDLE_HIGH = 2'b10,
        WAIT_LOW  = 2'b11
    } sw_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing an asynchronous level into the clock domain.
module sync_2ff (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic sync1_reg;
    logic sync2_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= d;
            sync2_reg <= sync1_reg;
        end
    end

    assign q = sync2_reg;

endmodule

// File: rtl/switch_conditioner.sv
// Debounces a bouncy physical switch, emits edge pulses, and toggles a
// downstream enable on every accepted press.
module switch_conditioner
    import switch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_switch,
    output logic level,
    output logic rise,
    output logic fall,
    output logic switch
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             sync_q;
    sw_state_t        state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             level_reg;
    logic             rise_reg;
    logic             fall_reg;
    logic             switch_reg;

    sync_2ff u_sync (
        .clock (clock),
        .reset (reset),
        .d     (raw_switch),
        .q     (sync_q)
    );

    // The counter tops out at DEBOUNCE_CYCLES: acceptance happens on the
    // following agreeing cycle, so it never increments past the limit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE_LOW;
            cnt_reg    <= '0;
            level_reg  <= 1'b0;
            rise_reg   <= 1'b0;
            fall_reg   <= 1'b0;
            switch_reg <= 1'b0;
        end else begin
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
            case (state_reg)
                IDLE_LOW: begin
                    if (sync_q) begin
                        state_reg <= WAIT_HIGH;
                        cnt_reg   <= CNT_ONE;
                    end else begin
                        cnt_reg <= '0;
                    end
                end
                WAIT_HIGH: begin
                    if (!sync_q) begin
                        state_reg <= IDLE_LOW;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == CNT_MAX) begin
                        state_reg  <= IDLE_HIGH;
                        cnt_reg    <= '0;
                        level_reg  <= 1'b1;
                        rise_reg   <= 1'b1;
                        switch_reg <= ~switch_reg;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end
                IDLE_HIGH: begin
                    if (!sync_q) begin
                        state_reg <= WAIT_LOW;
                        cnt_reg   <= CNT_ONE;
                    end else begin
                        cnt_reg <= '0;
                    end
                end
                WAIT_LOW: begin
                    if (sync_q) begin
                        state_reg <= IDLE_HIGH;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == CNT_MAX) begin
                        state_reg <= IDLE_LOW;
                        cnt_reg   <= '0;
                        level_reg <= 1'b0;
                        fall_reg  <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end
                default: begin
                    state_reg <= IDLE_LOW;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    assign level  = level_reg;
    assign rise   = rise_reg;
    assign fall   = fall_reg;
    assign switch = switch_reg;

endmodule

// File: tb/tb_switch_conditioner.sv
// Scoreboard bench: a behavioural model predicts outputs per clock edge and
// the DUT is compared on the following falling edge.
module tb_switch_conditioner;

    localparam int N = 4;

    logic clock      = 1'b0;
    logic reset      = 1'b0;
    logic raw_switch = 1'b0;
    logic level;
    logic rise;
    logic fall;
    logic switch;

    switch_conditioner #(.DEBOUNCE_CYCLES(N)) dut (
        .clock      (clock),
        .reset      (reset),
        .raw_switch (raw_switch),
        .level      (level),
        .rise       (rise),
        .fall       (fall),
        .switch     (switch)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic level;
        logic rise;
        logic fall;
        logic switch;
    } obs_t;

    obs_t exp_q[$];

    int check_count = 0;
    int error_count = 0;

    // Model: run counts consecutive edges where the synchronized input
    // disagrees with the accepted level; N+1 of them accept the new level.
    logic m_s1 = 1'b0, m_s2 = 1'b0;
    logic m_level = 1'b0, m_rise = 1'b0, m_fall = 1'b0, m_switch = 1'b0;
    int   m_run = 0;

    int edge_idx       = 0;
    int rise_count     = 0;
    int fall_count     = 0;
    int last_rise_edge = -1;

    task automatic check_val(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic model_zero();
        m_s1 = 1'b0; m_s2 = 1'b0; m_level = 1'b0;
        m_rise = 1'b0; m_fall = 1'b0; m_switch = 1'b0; m_run = 0;
    endtask

    task automatic model_edge();
        if (!reset) begin
            model_zero();
        end else begin
            m_rise = 1'b0;
            m_fall = 1'b0;
            if (m_s2 != m_level) m_run++;
            else                 m_run = 0;
            if (m_run == N + 1) begin
                m_run   = 0;
                m_level = m_s2;
                if (m_s2) begin
                    m_rise   = 1'b1;
                    m_switch = ~m_switch;
                end else begin
                    m_fall = 1'b1;
                end
            end
            m_s2 = m_s1;
            m_s1 = raw_switch;
        end
    endtask

    task automatic compare_out();
        obs_t e;
        if (exp_q.size() == 0) begin
            check_val("queue_empty", 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        check_val("level",  {31'd0, level},  {31'd0, e.level});
        check_val("rise",   {31'd0, rise},   {31'd0, e.rise});
        check_val("fall",   {31'd0, fall},   {31'd0, e.fall});
        check_val("switch", {31'd0, switch}, {31'd0, e.switch});
        check_val("rise_fall_excl", {31'd0, rise & fall}, 32'd0);
        if (rise === 1'b1) begin
            rise_count++;
            last_rise_edge = edge_idx;
        end
        if (fall === 1'b1) fall_count++;
    endtask

    task automatic step(input logic raw_v);
        obs_t e;
        raw_switch = raw_v;
        @(posedge clock);
        edge_idx++;
        model_edge();
        e.level = m_level; e.rise = m_rise; e.fall = m_fall; e.switch = m_switch;
        exp_q.push_back(e);
        @(negedge clock);
        compare_out();
    endtask

    // Asserts reset between edges and checks the outputs clear with no edge.
    task automatic async_reset_check(input string tag);
        reset = 1'b0;
        #1;
        model_zero();
        check_val({tag, "_level"},  {31'd0, level},  32'd0);
        check_val({tag, "_rise"},   {31'd0, rise},   32'd0);
        check_val({tag, "_fall"},   {31'd0, fall},   32'd0);
        check_val({tag, "_switch"}, {31'd0, switch}, 32'd0);
    endtask

    task automatic begin_scenario();
        edge_idx       = -1;
        rise_count     = 0;
        fall_count     = 0;
        last_rise_edge = -1;
    endtask

    initial begin
        // Power-on reset, then idle low
        #12;
        check_val("por_level",  {31'd0, level},  32'd0);
        check_val("por_rise",   {31'd0, rise},   32'd0);
        check_val("por_switch", {31'd0, switch}, 32'd0);
        #8;
        reset = 1'b1;
        begin_scenario();
        for (int i = 0; i < 50; i++) step(1'b0);
        check_val("idle_rises", rise_count, 0);
        $display("scenario idle_low: rises=%0d falls=%0d", rise_count, fall_count);

        // Clean press: rise exactly on edge N+2
        begin_scenario();
        for (int i = 0; i < 20; i++) step(1'b1);
        check_val("press_rise_edge", last_rise_edge, N + 2);
        check_val("press_rises", rise_count, 1);
        check_val("press_switch", {31'd0, switch}, 32'd1);
        for (int i = 0; i < 20; i++) step(1'b0);
        check_val("release_falls", fall_count, 1);
        $display("scenario clean_press: rise_edge=%0d rises=%0d falls=%0d",
                 last_rise_edge, rise_count, fall_count);

        // Short glitches: 3 and N cycles rejected, N+1 accepted
        begin_scenario();
        for (int i = 0; i < 3; i++)  step(1'b1);
        for (int i = 0; i < 20; i++) step(1'b0);
        check_val("glitch3_rises", rise_count, 0);
        for (int i = 0; i < N; i++)  step(1'b1);
        for (int i = 0; i < 20; i++) step(1'b0);
        check_val("glitchN_rises", rise_count, 0);
        for (int i = 0; i < N + 1; i++) step(1'b1);
        for (int i = 0; i < 20; i++)    step(1'b0);
        check_val("pulseN1_rises", rise_count, 1);
        check_val("pulseN1_falls", fall_count, 1);
        $display("scenario glitches: rises=%0d falls=%0d", rise_count, fall_count);

        // Fresh reset, then two press/release cycles
        async_reset_check("rst2");
        step(1'b0);
        reset = 1'b1;
        begin_scenario();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 20; i++) step(1'b1);
            check_val("pr_switch_on_press", {31'd0, switch}, (k == 0) ? 32'd1 : 32'd0);
            for (int i = 0; i < 20; i++) step(1'b0);
        end
        check_val("pr_rises", rise_count, 2);
        check_val("pr_falls", fall_count, 2);
        $display("scenario two_presses: rises=%0d falls=%0d", rise_count, fall_count);

        // Chatter every cycle, then settle high
        begin_scenario();
        for (int i = 0; i < 10; i++) step((i % 2) == 0);
        edge_idx = -1;
        for (int i = 0; i < 20; i++) step(1'b1);
        check_val("chatter_rises", rise_count, 1);
        check_val("chatter_rise_edge", last_rise_edge, N + 2);
        for (int i = 0; i < 20; i++) step(1'b0);
        $display("scenario chatter: rise_edge=%0d rises=%0d", last_rise_edge, rise_count);

        // Reset after edge 4 of a qualifying press, then requalify
        begin_scenario();
        for (int i = 0; i < 5; i++) step(1'b1);
        async_reset_check("midwait");
        step(1'b1);
        step(1'b1);
        check_val("midwait_no_rise", rise_count, 0);
        reset = 1'b1;
        edge_idx = -1;
        for (int i = 0; i < 15; i++) step(1'b1);
        check_val("requal_rises", rise_count, 1);
        check_val("requal_rise_edge_count", last_rise_edge + 1, 7);
        $display("scenario midwait_reset: rise_edge=%0d rises=%0d", last_rise_edge, rise_count);

        check_val("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule

// File: doc/switch_conditioner.md
SWITCH_CONDITIONER -- requirements
Module: switch_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable synchronized cycles required to accept a new input level; legal range 1..65535.
REQ-002 Port clock  input  1  single system clock; all state updates on its rising edge.
REQ-003 Port reset  input  1  asynchronous, active-low reset.
REQ-004 Port raw_switch  input  1  unsynchronized, bouncy physical switch level.
REQ-005 Port level  output  1  debounced switch level.
REQ-006 Port rise  output  1  one-cycle pulse on accepted 0->1 transition of level.
REQ-007 Port fall  output  1  one-cycle pulse on accepted 1->0 transition of level.
REQ-008 Port switch  output  1  latched enable for the downstream blinker; flips on every rise.

Function
REQ-009 raw_switch SHALL pass through a two-flop synchronizer (sync1, sync2); only sync2 SHALL drive the FSM.
REQ-010 FSM SHALL have exactly four states: IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW.
REQ-011 IDLE_LOW with sync2=1 -> WAIT_HIGH, counter loaded with 1; otherwise stay, counter 0.
REQ-012 WAIT_HIGH with sync2=0 -> IDLE_LOW, counter cleared; with sync2=1 and counter<DEBOUNCE_CYCLES -> counter+1.
REQ-013 WAIT_HIGH with sync2=1 and counter==DEBOUNCE_CYCLES -> IDLE_HIGH, level<=1, rise<=1, switch<=~switch, counter cleared.
REQ-014 IDLE_HIGH/WAIT_LOW SHALL mirror REQ-011..013 with polarity inverted; acceptance sets level<=0 and fall<=1, switch unchanged.
REQ-015 Latency: a clean raw edge arriving before edge 0 SHALL be visible on level after rising edge DEBOUNCE_CYCLES+2 (edge 6 for default 4).
REQ-016 Any excursion of sync2 lasting fewer than DEBOUNCE_CYCLES+1 cycles SHALL produce no change on level, rise, fall or switch.
REQ-017 rise and fall SHALL be registered, high for exactly one cycle, never high simultaneously, and low in every cycle not matching REQ-013/014.
REQ-018 Counter width SHALL be $clog2(DEBOUNCE_CYCLES+1) bits; counter SHALL never exceed DEBOUNCE_CYCLES nor wrap.
REQ-019 raw_switch held steady indefinitely SHALL leave all outputs constant and rise/fall low.
REQ-020 A bounce reverting during WAIT_* SHALL restart qualification from zero on the next opposite-level excursion.

Reset
REQ-021 reset low SHALL immediately, independent of clock, force state IDLE_LOW, counter 0, sync1/sync2 0, level 0, rise 0, fall 0, switch 0.
REQ-022 Reset asserted mid-WAIT_HIGH SHALL abandon qualification with no rise pulse emitted.
REQ-023 After reset deassertion with raw_switch already 1, a full qualification (REQ-015) SHALL occur before level rises.

Structure
REQ-024 State encoding (2-bit enumerated) and default DEBOUNCE_CYCLES constant SHALL live in shared package switch_pkg.
REQ-025 Synchronizer SHALL be a separate sub-module sync_2ff (clock, reset, d, q), reset value 0.
REQ-026 All outputs SHALL be driven directly from flops; no combinational path from raw_switch to any output.

Verification
REQ-027 Reset 0 for 20 ns then 1, raw_switch=0 -> all outputs 0 for 50 cycles.
REQ-028 Default N=4, raw_switch 0->1 before edge 0 and held -> level=1 and rise=1 after edge 6, rise=0 after edge 7, switch=1.
REQ-029 raw_switch pulses high for 3 cycles then low -> level, rise, switch remain 0.
REQ-030 Two clean press/release cycles, each held 20 cycles -> rise twice, fall twice, switch sequence 0->1->0, level follows with 6-edge latency.
REQ-031 raw_switch toggles every cycle for 10 cycles then settles at 1 -> exactly one rise, occurring DEBOUNCE_CYCLES+2 edges after settle.
REQ-032 reset asserted at edge 4 of a qualifying press -> outputs 0 immediately, no rise pulse; after release of reset with raw_switch=1, rise after 7 further edges.
